// File: rtl/noc_flit_rx.sv
// NoC link receiver: credit-based flit FIFO with packet framing tracking.
// Optional sticky error flags are enabled with the NOC_FLIT_RX_ERR_CHECK_EN macro.
module noc_flit_rx #(
    parameter int FLIT_WIDTH        = 64,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 4
) (
    input  logic                                clk_noc,
    input  logic                                rst_n,
    input  logic [FLIT_WIDTH-1:0]               data_in,
    input  logic [DEST_WIDTH-1:0]               dest_in,
    input  logic                                is_tail_in,
    input  logic                                send_in,
    output logic                                credit_out,
    output logic                                flit_valid,
    input  logic                                flit_ready,
    output logic [FLIT_WIDTH-1:0]               flit_data,
    output logic [DEST_WIDTH-1:0]               flit_dest,
    output logic                                flit_tail,
    output logic [$clog2(FLIT_BUFFER_DEPTH):0]  occupancy
`ifdef NOC_FLIT_RX_ERR_CHECK_EN
    ,
    output logic                                overflow_err,
    output logic                                framing_err
`endif
);

    localparam int PTR_W   = $clog2(FLIT_BUFFER_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FLIT_BUFFER_DEPTH);

    typedef enum logic {
        IDLE,
        IN_PKT
    } pkt_state_t;

    logic [ENTRY_W-1:0] mem [FLIT_BUFFER_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    pkt_state_t         state_q;
    pkt_state_t         next_state;
    logic               push;
    logic               pop;

    // A full buffer can still take a flit when the head leaves on the same edge.
    assign pop  = flit_valid && flit_ready;
    assign push = send_in && ((count_q < DEPTH_CNT) || pop);

    assign flit_valid = (count_q != '0);
    assign occupancy  = count_q;
    assign {flit_data, flit_dest, flit_tail} = mem[rd_ptr_q];

    always_ff @(posedge clk_noc) begin
        if (push) begin
            mem[wr_ptr_q] <= {data_in, dest_in, is_tail_in};
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_out <= 1'b0;
        end else begin
            credit_out <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state = state_q;
        if (push) begin
            next_state = is_tail_in ? IDLE : IN_PKT;
        end
    end

`ifdef NOC_FLIT_RX_ERR_CHECK_EN
    logic [DEST_WIDTH-1:0] head_dest_q;

    // The head dest is the reference every body flit of the packet must match.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            head_dest_q  <= '0;
            overflow_err <= 1'b0;
            framing_err  <= 1'b0;
        end else begin
            if (push && (state_q == IDLE)) begin
                head_dest_q <= dest_in;
            end
            if (send_in && !push) begin
                overflow_err <= 1'b1;
            end
            if (push && (state_q == IN_PKT) && (dest_in != head_dest_q)) begin
                framing_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_flit_rx.sv
// Directed testbench for noc_flit_rx; error-flag checks compile in with NOC_FLIT_RX_ERR_CHECK_EN.
module tb_noc_flit_rx;

    logic        clk_noc = 1'b0;
    logic        rst_n;
    logic [63:0] data_in;
    logic [5:0]  dest_in;
    logic        is_tail_in;
    logic        send_in;
    logic        credit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic [63:0] flit_data;
    logic [5:0]  flit_dest;
    logic        flit_tail;
    logic [2:0]  occupancy;
`ifdef NOC_FLIT_RX_ERR_CHECK_EN
    logic        overflow_err;
    logic        framing_err;
`endif

    int check_count = 0;
    int pass_count  = 0;

    noc_flit_rx #(
        .FLIT_WIDTH(64),
        .DEST_WIDTH(6),
        .FLIT_BUFFER_DEPTH(4)
    ) dut (
        .clk_noc(clk_noc),
        .rst_n(rst_n),
        .data_in(data_in),
        .dest_in(dest_in),
        .is_tail_in(is_tail_in),
        .send_in(send_in),
        .credit_out(credit_out),
        .flit_valid(flit_valid),
        .flit_ready(flit_ready),
        .flit_data(flit_data),
        .flit_dest(flit_dest),
        .flit_tail(flit_tail),
        .occupancy(occupancy)
`ifdef NOC_FLIT_RX_ERR_CHECK_EN
        ,
        .overflow_err(overflow_err),
        .framing_err(framing_err)
`endif
    );

    always #5 clk_noc = ~clk_noc;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic drive_flit(input logic [63:0] d, input logic [5:0] dst, input logic tl);
        send_in    = 1'b1;
        data_in    = d;
        dest_in    = dst;
        is_tail_in = tl;
        step();
        send_in    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        check_count++;
        if (flit_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", flit_valid);
        else pass_count++;
        check_count++;
        if (occupancy !== 3'd0) $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy);
        else pass_count++;
        check_count++;
        if (credit_out !== 1'b0) $display("[TB] FAIL reset_credit: got %b expected 0", credit_out);
        else pass_count++;
`ifdef NOC_FLIT_RX_ERR_CHECK_EN
        check_count++;
        if ({overflow_err, framing_err} !== 2'b00)
            $display("[TB] FAIL reset_errs: got %b expected 00", {overflow_err, framing_err});
        else pass_count++;
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        flit_ready = 1'b1;
        drive_flit(64'hA5, 6'h05, 1'b1);
        check_count++;
        if (flit_valid !== 1'b1) $display("[TB] FAIL single_valid: got %b expected 1", flit_valid);
        else pass_count++;
        check_count++;
        if ({flit_data, flit_dest, flit_tail} !== {64'hA5, 6'h05, 1'b1})
            $display("[TB] FAIL single_head: got %h/%h/%b expected a5/05/1", flit_data, flit_dest, flit_tail);
        else pass_count++;
        check_count++;
        if (credit_out !== 1'b0) $display("[TB] FAIL single_early_credit: got %b expected 0", credit_out);
        else pass_count++;
        step();
        check_count++;
        if (credit_out !== 1'b1) $display("[TB] FAIL single_credit: got %b expected 1", credit_out);
        else pass_count++;
        check_count++;
        if (occupancy !== 3'd0) $display("[TB] FAIL single_empty: got %0d expected 0", occupancy);
        else pass_count++;
        step();
        check_count++;
        if (credit_out !== 1'b0) $display("[TB] FAIL single_credit_pulse: got %b expected 0", credit_out);
        else pass_count++;
    endtask

    task automatic test_fill();
        flit_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_flit(64'(i), 6'h02, 1'b1);
            check_count++;
            if (occupancy !== 3'(i) || credit_out !== 1'b0)
                $display("[TB] FAIL fill_occ_%0d: got occ=%0d credit=%b expected occ=%0d credit=0", i, occupancy, credit_out, i);
            else pass_count++;
        end
        flit_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_count++;
            if (flit_valid !== 1'b1 || flit_data !== 64'(i))
                $display("[TB] FAIL fill_order_%0d: got valid=%b data=%h expected valid=1 data=%h", i, flit_valid, flit_data, i);
            else pass_count++;
            step();
            check_count++;
            if (credit_out !== 1'b1) $display("[TB] FAIL fill_credit_%0d: got %b expected 1", i, credit_out);
            else pass_count++;
        end
        check_count++;
        if (occupancy !== 3'd0 || flit_valid !== 1'b0)
            $display("[TB] FAIL fill_drained: got occ=%0d valid=%b expected occ=0 valid=0", occupancy, flit_valid);
        else pass_count++;
        step();
        check_count++;
        if (credit_out !== 1'b0) $display("[TB] FAIL fill_credit_end: got %b expected 0", credit_out);
        else pass_count++;
    endtask

    task automatic test_full_simul();
        logic [63:0] expected [4];
        expected = '{64'h6, 64'h7, 64'h8, 64'h9};
        flit_ready = 1'b0;
        for (int i = 5; i <= 8; i++) drive_flit(64'(i), 6'h01, 1'b1);
        flit_ready = 1'b1;
        drive_flit(64'h9, 6'h01, 1'b1);
        flit_ready = 1'b0;
        check_count++;
        if (occupancy !== 3'd4) $display("[TB] FAIL full_simul_occ: got %0d expected 4", occupancy);
        else pass_count++;
        check_count++;
        if (credit_out !== 1'b1) $display("[TB] FAIL full_simul_credit: got %b expected 1", credit_out);
        else pass_count++;
`ifdef NOC_FLIT_RX_ERR_CHECK_EN
        check_count++;
        if (overflow_err !== 1'b0) $display("[TB] FAIL full_simul_overflow: got %b expected 0", overflow_err);
        else pass_count++;
`endif
        flit_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_count++;
            if (flit_data !== expected[i])
                $display("[TB] FAIL full_simul_order_%0d: got %h expected %h", i, flit_data, expected[i]);
            else pass_count++;
            step();
        end
        check_count++;
        if (flit_valid !== 1'b0) $display("[TB] FAIL full_simul_drained: got %b expected 0", flit_valid);
        else pass_count++;
        flit_ready = 1'b0;
        step();
    endtask

    task automatic test_framing_ok();
        flit_ready = 1'b0;
        drive_flit(64'h31, 6'h03, 1'b0);
        drive_flit(64'h32, 6'h03, 1'b0);
        drive_flit(64'h33, 6'h03, 1'b1);
`ifdef NOC_FLIT_RX_ERR_CHECK_EN
        check_count++;
        if (framing_err !== 1'b0) $display("[TB] FAIL framing_ok_flag: got %b expected 0", framing_err);
        else pass_count++;
`endif
        flit_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check_count++;
            if (flit_data !== 64'h30 + 64'(i) || flit_tail !== (i == 3))
                $display("[TB] FAIL framing_ok_flit_%0d: got %h/%b expected %h/%b", i, flit_data, flit_tail, 64'h30 + 64'(i), (i == 3));
            else pass_count++;
            step();
        end
        flit_ready = 1'b0;
        step();
    endtask

    task automatic test_framing_bad();
        flit_ready = 1'b0;
        drive_flit(64'h41, 6'h03, 1'b0);
        drive_flit(64'h42, 6'h07, 1'b1);
`ifdef NOC_FLIT_RX_ERR_CHECK_EN
        check_count++;
        if (framing_err !== 1'b1) $display("[TB] FAIL framing_bad_flag: got %b expected 1", framing_err);
        else pass_count++;
`endif
        check_count++;
        if (flit_dest !== 6'h03 || occupancy !== 3'd2)
            $display("[TB] FAIL framing_bad_head: got dest=%h occ=%0d expected dest=03 occ=2", flit_dest, occupancy);
        else pass_count++;
        flit_ready = 1'b1;
        step();
        step();
        flit_ready = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        int credits;
        flit_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_flit(64'hA + 64'(i), 6'h04, 1'b1);
        drive_flit(64'hE, 6'h04, 1'b1);
        check_count++;
        if (occupancy !== 3'd4 || credit_out !== 1'b0)
            $display("[TB] FAIL overflow_drop: got occ=%0d credit=%b expected occ=4 credit=0", occupancy, credit_out);
        else pass_count++;
`ifdef NOC_FLIT_RX_ERR_CHECK_EN
        check_count++;
        if (overflow_err !== 1'b1) $display("[TB] FAIL overflow_flag: got %b expected 1", overflow_err);
        else pass_count++;
`endif
        flit_ready = 1'b1;
        credits = 0;
        for (int i = 0; i < 4; i++) begin
            check_count++;
            if (flit_data !== 64'hA + 64'(i))
                $display("[TB] FAIL overflow_order_%0d: got %h expected %h", i, flit_data, 64'hA + 64'(i));
            else pass_count++;
            step();
            if (credit_out === 1'b1) credits++;
        end
        flit_ready = 1'b0;
        step();
        if (credit_out === 1'b1) credits++;
        check_count++;
        if (credits != 4 || flit_valid !== 1'b0)
            $display("[TB] FAIL overflow_credits: got credits=%0d valid=%b expected credits=4 valid=0", credits, flit_valid);
        else pass_count++;
`ifdef NOC_FLIT_RX_ERR_CHECK_EN
        check_count++;
        if (overflow_err !== 1'b1) $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow_err);
        else pass_count++;
`endif
    endtask

    task automatic test_reset_mid();
        flit_ready = 1'b0;
        drive_flit(64'h11, 6'h03, 1'b0);
        drive_flit(64'h22, 6'h03, 1'b0);
        check_count++;
        if (occupancy !== 3'd2) $display("[TB] FAIL reset_mid_pre_occ: got %0d expected 2", occupancy);
        else pass_count++;
        rst_n = 1'b0;
        step();
        step();
        check_count++;
        if ({flit_valid, occupancy, credit_out} !== 5'b0)
            $display("[TB] FAIL reset_mid_state: got valid=%b occ=%0d credit=%b expected 0/0/0", flit_valid, occupancy, credit_out);
        else pass_count++;
`ifdef NOC_FLIT_RX_ERR_CHECK_EN
        check_count++;
        if ({overflow_err, framing_err} !== 2'b00)
            $display("[TB] FAIL reset_mid_errs: got %b expected 00", {overflow_err, framing_err});
        else pass_count++;
`endif
        rst_n = 1'b1;
        flit_ready = 1'b1;
        drive_flit(64'h55, 6'h09, 1'b1);
        check_count++;
        if (flit_valid !== 1'b1 || flit_data !== 64'h55 || flit_dest !== 6'h09)
            $display("[TB] FAIL reset_mid_deliver: got valid=%b data=%h dest=%h expected 1/55/09", flit_valid, flit_data, flit_dest);
        else pass_count++;
        step();
        check_count++;
        if (credit_out !== 1'b1 || occupancy !== 3'd0)
            $display("[TB] FAIL reset_mid_credit: got credit=%b occ=%0d expected 1/0", credit_out, occupancy);
        else pass_count++;
    endtask

    initial begin
        rst_n      = 1'b0;
        data_in    = '0;
        dest_in    = '0;
        is_tail_in = 1'b0;
        send_in    = 1'b0;
        flit_ready = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_full_simul();
        test_framing_ok();
        test_framing_bad();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
